// File: rtl/seven_seg_capture_if.sv
// Display-bus bundle between a multiplexed 2-digit 7-segment source and the capture block.
// The slave modport is the capture side; the master modport drives the bus and observes results.
interface seven_seg_capture_if;
    logic [6:0] seg_n_i;
    logic       dsel_i;
    logic [7:0] value_o;
    logic       valid_o;
    logic       err_o;
    logic       active_o;

    modport slave (
        input  seg_n_i,
        input  dsel_i,
        output value_o,
        output valid_o,
        output err_o,
        output active_o
    );

    modport master (
        output seg_n_i,
        output dsel_i,
        input  value_o,
        input  valid_o,
        input  err_o,
        input  active_o
    );
endinterface

// File: rtl/seven_seg_capture.sv
// Receives a multiplexed active-low 2-digit 7-segment bus, debounces each digit,
// decodes segments back to nibbles and emits complete {hi, lo} frames.
module seven_seg_capture #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter bit BCD_ONLY       = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    seven_seg_capture_if.slave  bus
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [6:0]    seg_s1_q, seg_s2_q;
    logic          dsel_s1_q, dsel_s2_q;
    logic [7:0]    w;
    logic [7:0]    w_prev_q;
    logic [SW-1:0] stab_cnt_q, stab_cnt_d;
    logic          cap_q, cap_d;
    logic [7:0]    cap_w_q;
    logic [3:0]    lo_slot_q, hi_slot_q;
    logic          have_lo_q, have_lo_d;
    logic          have_hi_q, have_hi_d;
    logic [1:0]    state_q, state_d;
    logic [7:0]    value_q;
    logic          valid_q;
    logic          err_q;
    logic          active_q, active_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    logic [4:0]    dec;
    logic          cap_ok, cap_bad, cap_lo, cap_hi;
    logic          timeout_hit;

    // Returns {ok, nibble}; active-high segments ordered g..a.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        r = 5'h00;
        case (seg)
            7'h3F: r = {1'b1, 4'h0};
            7'h06: r = {1'b1, 4'h1};
            7'h5B: r = {1'b1, 4'h2};
            7'h4F: r = {1'b1, 4'h3};
            7'h66: r = {1'b1, 4'h4};
            7'h6D: r = {1'b1, 4'h5};
            7'h7D: r = {1'b1, 4'h6};
            7'h07: r = {1'b1, 4'h7};
            7'h7F: r = {1'b1, 4'h8};
            7'h6F: r = {1'b1, 4'h9};
            7'h77: r = {!BCD_ONLY, 4'hA};
            7'h7C: r = {!BCD_ONLY, 4'hB};
            7'h39: r = {!BCD_ONLY, 4'hC};
            7'h5E: r = {!BCD_ONLY, 4'hD};
            7'h79: r = {!BCD_ONLY, 4'hE};
            7'h71: r = {!BCD_ONLY, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    assign w = {dsel_s2_q, ~seg_s2_q};

    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (w != w_prev_q)
            stab_cnt_d = '0;
        else if (stab_cnt_q != SW'(STABLE_CYCLES))
            stab_cnt_d = stab_cnt_q + SW'(1);
    end

    // Strobe exactly once, on the edge where the counter saturates.
    assign cap_d = (w == w_prev_q) && (stab_cnt_q == SW'(STABLE_CYCLES - 1));

    assign dec         = decode_seg(cap_w_q[6:0]);
    assign cap_ok      = cap_q && dec[4];
    assign cap_bad     = cap_q && !dec[4];
    assign cap_lo      = cap_ok && cap_w_q[7];
    assign cap_hi      = cap_ok && !cap_w_q[7];
    assign timeout_hit = !cap_ok && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        have_lo_d = have_lo_q;
        have_hi_d = have_hi_q;
        if (state_q == ST_FULL || timeout_hit) begin
            have_lo_d = 1'b0;
            have_hi_d = 1'b0;
        end
        if (cap_lo)
            have_lo_d = 1'b1;
        if (cap_hi)
            have_hi_d = 1'b1;
    end

    always_comb begin
        state_d = ST_HALF;
        case ({have_hi_d, have_lo_d})
            2'b00:   state_d = ST_EMPTY;
            2'b11:   state_d = ST_FULL;
            default: state_d = ST_HALF;
        endcase
    end

    always_comb begin
        to_cnt_d = to_cnt_q;
        active_d = active_q;
        if (cap_ok) begin
            to_cnt_d = '0;
            active_d = 1'b1;
        end else if (to_cnt_q != TW'(TIMEOUT_CYCLES)) begin
            to_cnt_d = to_cnt_q + TW'(1);
            if (timeout_hit)
                active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q   <= '0;
            seg_s2_q   <= '0;
            dsel_s1_q  <= 1'b0;
            dsel_s2_q  <= 1'b0;
            w_prev_q   <= '0;
            stab_cnt_q <= '0;
            cap_q      <= 1'b0;
            cap_w_q    <= '0;
            lo_slot_q  <= '0;
            hi_slot_q  <= '0;
            have_lo_q  <= 1'b0;
            have_hi_q  <= 1'b0;
            state_q    <= ST_EMPTY;
            value_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            active_q   <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            seg_s1_q   <= bus.seg_n_i;
            seg_s2_q   <= seg_s1_q;
            dsel_s1_q  <= bus.dsel_i;
            dsel_s2_q  <= dsel_s1_q;
            w_prev_q   <= w;
            stab_cnt_q <= stab_cnt_d;
            cap_q      <= cap_d;
            if (cap_d)
                cap_w_q <= w;
            if (cap_lo)
                lo_slot_q <= dec[3:0];
            if (cap_hi)
                hi_slot_q <= dec[3:0];
            have_lo_q  <= have_lo_d;
            have_hi_q  <= have_hi_d;
            state_q    <= state_d;
            valid_q    <= (state_q == ST_FULL);
            if (state_q == ST_FULL)
                value_q <= {hi_slot_q, lo_slot_q};
            err_q      <= cap_bad;
            active_q   <= active_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign bus.value_o  = value_q;
    assign bus.valid_o  = valid_q;
    assign bus.err_o    = err_q;
    assign bus.active_o = active_q;
endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture: two instances (BCD-only and full-hex) watch the same bus.
module tb_seven_seg_capture;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    seven_seg_capture_if bus_a ();
    seven_seg_capture_if bus_b ();

    assign bus_b.seg_n_i = bus_a.seg_n_i;
    assign bus_b.dsel_i  = bus_a.dsel_i;

    seven_seg_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(64), .BCD_ONLY(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    seven_seg_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(64), .BCD_ONLY(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    always #5 clk = ~clk;

    // Active-high segment patterns (g..a) for hex digits 0..F.
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_checks = 0;
    int n_fail   = 0;
    int err_a    = 0;
    int err_b    = 0;
    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];

    task automatic push_both(input logic [7:0] v);
        exp_a.push_back(v);
        exp_b.push_back(v);
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus_a.valid_o === 1'b1) begin
                    n_checks++;
                    if (exp_a.size() == 0) begin
                        n_fail++;
                        $display("FAIL valid_a_unexpected: value_o=%h with no frame pending", bus_a.value_o);
                    end else begin
                        e = exp_a.pop_front();
                        $display("frame a value_o=%h expected=%h", bus_a.value_o, e);
                        if (bus_a.value_o !== e) begin
                            n_fail++;
                            $display("FAIL frame_a: value_o=%h required=%h", bus_a.value_o, e);
                        end
                    end
                end
                if (bus_b.valid_o === 1'b1) begin
                    n_checks++;
                    if (exp_b.size() == 0) begin
                        n_fail++;
                        $display("FAIL valid_b_unexpected: value_o=%h with no frame pending", bus_b.value_o);
                    end else begin
                        e = exp_b.pop_front();
                        $display("frame b value_o=%h expected=%h", bus_b.value_o, e);
                        if (bus_b.value_o !== e) begin
                            n_fail++;
                            $display("FAIL frame_b: value_o=%h required=%h", bus_b.value_o, e);
                        end
                    end
                end
                if (bus_a.err_o === 1'b1) err_a++;
                if (bus_b.err_o === 1'b1) err_b++;
            end
        end
    endtask

    // All stimulus tasks start and end one time unit after a rising edge.
    task automatic drive(input logic d, input logic [6:0] seg_on, input int cycles);
        bus_a.dsel_i  = d;
        bus_a.seg_n_i = ~seg_on;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic show(input logic d, input int nib, input int cycles);
        drive(d, seg_tab[nib], cycles);
    endtask

    task automatic apply_reset();
        bus_a.dsel_i  = 1'b0;
        bus_a.seg_n_i = 7'h7F;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_drain(input string name);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: pending frames a=%0d b=%0d required=0", name, exp_a.size(), exp_b.size());
            exp_a.delete();
            exp_b.delete();
        end
    endtask

    task automatic test_reset();
        bus_a.dsel_i  = 1'b0;
        bus_a.seg_n_i = 7'h7F;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus_a.value_o, bus_a.valid_o, bus_a.err_o, bus_a.active_o} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_state: value=%h valid=%b err=%b active=%b required 00/0/0/0",
                     bus_a.value_o, bus_a.valid_o, bus_a.err_o, bus_a.active_o);
        end
        apply_reset();
    endtask

    task automatic test_frame();
        int first;
        int pulses;
        apply_reset();
        push_both(8'h31);
        show(1'b1, 1, 20);
        bus_a.dsel_i  = 1'b0;
        bus_a.seg_n_i = ~seg_tab[3];
        first  = 0;
        pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus_a.valid_o === 1'b1) begin
                pulses++;
                if (first == 0) first = c;
            end
        end
        n_checks++;
        if (first - 1 != 8) begin
            n_fail++;
            $display("FAIL frame_latency: valid after %0d edges required 8", first - 1);
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL frame_pulses: %0d valid cycles required 1", pulses);
        end
        test_drain("frame");
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        push_both(8'h42);
        show(1'b1, 2, 20);
        show(1'b0, 4, 20);
        show(1'b1, 9, 20);
        n_checks++;
        if (bus_a.active_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_active_before: active_o=%b required 1", bus_a.active_o);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus_a.value_o, bus_a.valid_o, bus_a.active_o} !== 10'h000) begin
            n_fail++;
            $display("FAIL midframe_reset: value=%h valid=%b active=%b required 00/0/0",
                     bus_a.value_o, bus_a.valid_o, bus_a.active_o);
        end
        bus_a.dsel_i  = 1'b0;
        bus_a.seg_n_i = ~seg_tab[2];
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        show(1'b0, 2, 20);
        push_both(8'h28);
        show(1'b1, 8, 20);
        test_drain("midframe");
    endtask

    task automatic test_glitch();
        int ea;
        apply_reset();
        push_both(8'h25);
        show(1'b1, 5, 20);
        show(1'b0, 2, 20);
        ea = err_a;
        show(1'b1, 3, 20);
        drive(1'b0, seg_tab[8], 3);
        show(1'b1, 3, 20);
        n_checks++;
        if (bus_a.value_o !== 8'h25) begin
            n_fail++;
            $display("FAIL glitch_value: value_o=%h required=25", bus_a.value_o);
        end
        n_checks++;
        if (err_a != ea) begin
            n_fail++;
            $display("FAIL glitch_err: %0d err pulses required 0", err_a - ea);
        end
        push_both(8'h73);
        show(1'b0, 7, 20);
        test_drain("glitch");
    endtask

    task automatic test_invalid();
        int ea;
        int eb;
        apply_reset();
        ea = err_a;
        eb = err_b;
        exp_b.push_back(8'h1A);
        show(1'b1, 10, 20);
        show(1'b0, 1, 20);
        n_checks++;
        if (err_a - ea != 1) begin
            n_fail++;
            $display("FAIL invalid_err_bcd: %0d err pulses required 1", err_a - ea);
        end
        n_checks++;
        if (err_b != eb) begin
            n_fail++;
            $display("FAIL invalid_err_hex: %0d err pulses required 0", err_b - eb);
        end
        n_checks++;
        if (bus_a.value_o !== 8'h00) begin
            n_fail++;
            $display("FAIL invalid_value_bcd: value_o=%h required=00", bus_a.value_o);
        end
        test_drain("invalid");
    endtask

    task automatic test_timeout();
        int rise;
        int high;
        apply_reset();
        bus_a.dsel_i  = 1'b1;
        bus_a.seg_n_i = ~seg_tab[4];
        rise = 0;
        for (int c = 1; c <= 40 && rise == 0; c++) begin
            @(posedge clk);
            #1;
            if (bus_a.active_o === 1'b1) rise = c;
        end
        n_checks++;
        if (rise == 0) begin
            n_fail++;
            $display("FAIL timeout_rise: active_o=%b after 40 cycles required 1", bus_a.active_o);
        end
        high = (rise != 0) ? 1 : 0;
        for (int c = 0; c < 200 && high != 0; c++) begin
            @(posedge clk);
            #1;
            if (bus_a.active_o === 1'b1) high++;
            else break;
        end
        n_checks++;
        if (high != 64) begin
            n_fail++;
            $display("FAIL timeout_length: active_o high %0d cycles required 64", high);
        end
        show(1'b0, 6, 30);
        n_checks++;
        if (bus_a.active_o !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_reactivate: active_o=%b required 1", bus_a.active_o);
        end
        test_drain("timeout");
    endtask

    task automatic test_mux_sweep();
        int ea;
        int eb;
        int v;
        apply_reset();
        ea = err_a;
        eb = err_b;
        for (int n = 0; n <= 100; n++) begin
            v = n % 100;
            push_both({4'(v / 10), 4'(v % 10)});
            show(1'b1, v % 10, 32);
            show(1'b0, v / 10, 32);
        end
        n_checks++;
        if (err_a != ea || err_b != eb) begin
            n_fail++;
            $display("FAIL sweep_err: err pulses a=%0d b=%0d required 0", err_a - ea, err_b - eb);
        end
        n_checks++;
        if (bus_a.value_o !== 8'h00) begin
            n_fail++;
            $display("FAIL sweep_wrap: value_o=%h required=00", bus_a.value_o);
        end
        test_drain("sweep");
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_frame();
        test_reset_midframe();
        test_glitch();
        test_invalid();
        test_timeout();
        test_mux_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
